// File: rtl/hazard_ctrl.sv
// Hazard control for the 5-stage pipeline: load-use bubbles, branch flushes,
// memory-wait freeze with timeout, and saturating performance counters.
module hazard_ctrl #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       IF_ID_RSaddr_i,
  input  logic [4:0]       IF_ID_RTaddr_i,
  input  logic [4:0]       ID_EX_RTaddr_i,
  input  logic             ID_EX_MemRead_i,
  input  logic             branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  input  logic             cnt_clr_i,
  output logic             PC_write_o,
  output logic             IF_ID_write_o,
  output logic             IF_ID_flush_o,
  output logic             ID_EX_bubble_o,
  output logic             pipe_stall_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] wait_cnt_o,
  output logic             err_o
);

  localparam logic ST_RUN  = 1'b0;
  localparam logic ST_WAIT = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_M1  = CNT_W'(TIMEOUT - 1);

  logic             state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;

  logic memwait_c, loaduse_c, bubble_c, flush_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Hazard detection; register 0 never creates a dependency
  always_comb begin
    memwait_c = dmem_req_i & ~dmem_ready_i;
    loaduse_c = ID_EX_MemRead_i & (ID_EX_RTaddr_i != 5'd0) &
                ((ID_EX_RTaddr_i == IF_ID_RSaddr_i) |
                 (ID_EX_RTaddr_i == IF_ID_RTaddr_i));
    bubble_c  = ~memwait_c & loaduse_c;
    flush_c   = ~memwait_c & ~loaduse_c & branch_taken_i;
  end

  // Zero-latency pipeline control, memwait > load-use > branch > run
  always_comb begin
    PC_write_o     = 1'b1;
    IF_ID_write_o  = 1'b1;
    IF_ID_flush_o  = 1'b0;
    ID_EX_bubble_o = 1'b0;
    pipe_stall_o   = 1'b0;
    if (memwait_c) begin
      PC_write_o    = 1'b0;
      IF_ID_write_o = 1'b0;
      pipe_stall_o  = 1'b1;
    end else if (loaduse_c) begin
      PC_write_o     = 1'b0;
      IF_ID_write_o  = 1'b0;
      ID_EX_bubble_o = 1'b1;
    end else if (branch_taken_i) begin
      IF_ID_flush_o = 1'b1;
    end
  end

  // Next state: FSM, wait timer, sticky timeout flag and counters
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    err_d       = err_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    wait_cnt_d  = wait_cnt_q;

    case (state_q)
      ST_RUN:  if (memwait_c)  state_d = ST_WAIT;
      ST_WAIT: if (!memwait_c) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase

    if (state_q == ST_WAIT) begin
      if (timer_q != TMO) timer_d = timer_q + CNT_W'(1);
      if (timer_q >= TMO_M1) err_d = 1'b1;
    end else begin
      timer_d = '0;
    end

    if (bubble_c)  stall_cnt_d = sat_inc(stall_cnt_q);
    if (flush_c)   flush_cnt_d = sat_inc(flush_cnt_q);
    if (memwait_c) wait_cnt_d  = sat_inc(wait_cnt_q);

    // Clear wins over any increment or timeout in the same cycle
    if (cnt_clr_i) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
      wait_cnt_d  = '0;
      err_d       = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_RUN;
      timer_q     <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
  assign wait_cnt_o  = wait_cnt_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (CNT_W=3, TIMEOUT=4): directed vectors push
// expected outputs, a negedge monitor pops and compares.
module tb_hazard_ctrl;

  localparam logic [4:0] RUNC  = 5'b11000; // {pc_w, ifid_w, flush, bubble, stall}
  localparam logic [4:0] FLUSH = 5'b11100;
  localparam logic [4:0] BUB   = 5'b00010;
  localparam logic [4:0] FRZ   = 5'b00001;

  typedef struct packed {
    logic [4:0] ctl;
    logic [2:0] s;
    logic [2:0] f;
    logic [2:0] w;
    logic       e;
  } exp_t;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [4:0] IF_ID_RSaddr_i = '0, IF_ID_RTaddr_i = '0, ID_EX_RTaddr_i = '0;
  logic       ID_EX_MemRead_i = 1'b0, branch_taken_i = 1'b0;
  logic       dmem_req_i = 1'b0, dmem_ready_i = 1'b0, cnt_clr_i = 1'b0;
  logic       PC_write_o, IF_ID_write_o, IF_ID_flush_o, ID_EX_bubble_o, pipe_stall_o;
  logic [2:0] stall_cnt_o, flush_cnt_o, wait_cnt_o;
  logic       err_o;

  exp_t exp_q[$];
  exp_t exp_v, act_v, push_v;
  int   checks = 0;
  int   errors = 0;
  int   vec    = 0;

  hazard_ctrl #(.CNT_W(3), .TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .IF_ID_RSaddr_i(IF_ID_RSaddr_i), .IF_ID_RTaddr_i(IF_ID_RTaddr_i),
    .ID_EX_RTaddr_i(ID_EX_RTaddr_i), .ID_EX_MemRead_i(ID_EX_MemRead_i),
    .branch_taken_i(branch_taken_i), .dmem_req_i(dmem_req_i),
    .dmem_ready_i(dmem_ready_i), .cnt_clr_i(cnt_clr_i),
    .PC_write_o(PC_write_o), .IF_ID_write_o(IF_ID_write_o),
    .IF_ID_flush_o(IF_ID_flush_o), .ID_EX_bubble_o(ID_EX_bubble_o),
    .pipe_stall_o(pipe_stall_o), .stall_cnt_o(stall_cnt_o),
    .flush_cnt_o(flush_cnt_o), .wait_cnt_o(wait_cnt_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // Expected counters are the values visible during the cycle, before its edge
  task automatic step(input logic rn, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] exrt, input logic mr, input logic br,
                      input logic req, input logic rdy, input logic clr,
                      input logic [4:0] ctl, input int s, input int f,
                      input int w, input logic e);
    @(posedge clk_i);
    #1;
    rst_i = rn; IF_ID_RSaddr_i = rs; IF_ID_RTaddr_i = rt; ID_EX_RTaddr_i = exrt;
    ID_EX_MemRead_i = mr; branch_taken_i = br; dmem_req_i = req;
    dmem_ready_i = rdy; cnt_clr_i = clr;
    push_v.ctl = ctl; push_v.s = 3'(s); push_v.f = 3'(f);
    push_v.w = 3'(w); push_v.e = e;
    exp_q.push_back(push_v);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk_i);
      if (exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
        act_v = {PC_write_o, IF_ID_write_o, IF_ID_flush_o, ID_EX_bubble_o,
                 pipe_stall_o, stall_cnt_o, flush_cnt_o, wait_cnt_o, err_o};
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL vec%0d: got ctl=%b stall=%0d flush=%0d wait=%0d err=%b, expected ctl=%b stall=%0d flush=%0d wait=%0d err=%b",
                   vec, act_v.ctl, act_v.s, act_v.f, act_v.w, act_v.e,
                   exp_v.ctl, exp_v.s, exp_v.f, exp_v.w, exp_v.e);
        end
        vec++;
      end
    end
  end

  initial begin : stim
    int n;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, RUNC,  0, 0, 0, 0); // in reset
    step(1, 5, 0, 5, 1, 0, 0, 0, 0, BUB,   0, 0, 0, 0); // load-use on rs
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, RUNC,  1, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0, 0, 0, RUNC,  1, 0, 0, 0); // r0 never stalls
    step(1, 0, 0, 0, 0, 1, 0, 0, 0, FLUSH, 1, 0, 0, 0); // taken branch
    step(1, 0, 7, 7, 1, 1, 0, 0, 0, BUB,   1, 1, 0, 0); // load-use beats branch
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, FRZ,   2, 1, 0, 0); // memwait x3
    step(1, 5, 0, 5, 1, 0, 1, 0, 0, FRZ,   2, 1, 1, 0); // no bubble under memwait
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, FRZ,   2, 1, 2, 0);
    step(1, 5, 0, 5, 1, 0, 1, 1, 0, BUB,   2, 1, 3, 0); // ready: hazard reappears
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, RUNC,  3, 1, 3, 0);
    for (int i = 0; i < 6; i++)                          // timeout, wait_cnt saturates
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, FRZ, 3, 1, (3 + i < 7) ? 3 + i : 7, (i == 5));
    step(1, 0, 0, 0, 0, 0, 1, 1, 0, RUNC,  3, 1, 7, 1); // err sticky after ready
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, RUNC,  3, 1, 7, 1);
    step(1, 0, 0, 0, 0, 1, 0, 0, 1, FLUSH, 3, 1, 7, 1); // clear overrides flush inc
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, RUNC,  0, 0, 0, 0);
    for (int i = 0; i < 10; i++)                         // stall_cnt saturation
      step(1, 5, 0, 5, 1, 0, 0, 0, 0, BUB, (i < 7) ? i : 7, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, RUNC,  7, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, FRZ,   7, 0, 0, 0); // enter WAIT
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, FRZ,   7, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ,   0, 0, 0, 0); // async reset mid-wait
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, RUNC,  0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, FRZ,   0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, RUNC,  0, 0, 1, 0);
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(posedge clk_i);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard control unit for the 5-stage pipeline, companion to the forwarding unit: the forwarding unit resolves RAW hazards by steering EX operands; hazard_ctrl handles the cases forwarding cannot resolve.
- Inserts load-use bubbles, flushes IF/ID on taken branches, and freezes the pipeline while data memory is not ready.
- Keeps a memory-wait timeout and saturating performance counters.

Parameters:
- CNT_W, 16, width of the performance counters
- TIMEOUT, 255, maximum memory-wait cycles before err_o is set (1..2^CNT_W-1)

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset, asynchronous, active-low
- IF_ID_RSaddr_i  input  5  rs field of the instruction in ID
- IF_ID_RTaddr_i  input  5  rt field of the instruction in ID
- ID_EX_RTaddr_i  input  5  destination rt of the instruction in EX
- ID_EX_MemRead_i  input  1  instruction in EX is a load
- branch_taken_i  input  1  branch in ID resolved taken
- dmem_req_i  input  1  EX/MEM instruction accesses data memory this cycle
- dmem_ready_i  input  1  data memory completes the access this cycle
- cnt_clr_i  input  1  synchronous clear of counters and err_o
- PC_write_o  output  1  PC update enable
- IF_ID_write_o  output  1  IF/ID register write enable
- IF_ID_flush_o  output  1  IF/ID register zeroed (NOP) on next edge
- ID_EX_bubble_o  output  1  ID/EX control bits zeroed on next edge
- pipe_stall_o  output  1  freeze ID/EX, EX/MEM and MEM/WB
- stall_cnt_o  output  CNT_W  load-use stall cycles (saturating)
- flush_cnt_o  output  CNT_W  branch flushes (saturating)
- wait_cnt_o  output  CNT_W  memory-wait cycles (saturating)
- err_o  output  1  sticky memory-timeout flag

Behaviour:
- Reset (rst_i=0, asynchronous): state=RUN; all counters 0; err_o=0; wait timer 0. The control outputs follow the combinational rules below and take their RUN values.
- Hazard terms:
  - memwait = dmem_req_i & ~dmem_ready_i.
  - loaduse = ID_EX_MemRead_i & (ID_EX_RTaddr_i!=0) & (ID_EX_RTaddr_i==IF_ID_RSaddr_i | ID_EX_RTaddr_i==IF_ID_RTaddr_i).
- Control outputs are combinational, with zero latency, in strict priority order:
  1. memwait: PC_write_o=0, IF_ID_write_o=0, pipe_stall_o=1, ID_EX_bubble_o=0, IF_ID_flush_o=0. The whole pipe freezes and nothing is lost.
  2. else loaduse: PC_write_o=0, IF_ID_write_o=0, ID_EX_bubble_o=1, IF_ID_flush_o=0, pipe_stall_o=0.
  3. else branch_taken_i: IF_ID_flush_o=1, PC_write_o=1, IF_ID_write_o=1, others 0.
  4. else: PC_write_o=1, IF_ID_write_o=1, others 0.
- A load-use hazard coincident with a taken branch: the stall wins and the branch is re-evaluated next cycle with the forwarded value. A load-use hazard during memwait produces no bubble; the hazard re-appears once memwait clears.
- FSM, updated on the clk_i rising edge:
  - RUN -> WAIT when memwait.
  - WAIT -> RUN when ~memwait; this includes dmem_req_i dropping.
  - WAIT -> WAIT otherwise.
- Wait timer:
  - Cleared in RUN; increments each cycle in WAIT.
  - When the timer reaches TIMEOUT while still in WAIT, err_o is set.
  - err_o stays 1 until cnt_clr_i or reset. The pipeline stays frozen; err_o does not release the stall.
- Counters, on the clock edge, each saturating at 2^CNT_W-1 with no wrap:
  - stall_cnt_o increments on cycles where rule 2 is active.
  - flush_cnt_o increments on cycles where rule 3 is active.
  - wait_cnt_o increments on cycles where memwait=1.
- cnt_clr_i=1 zeroes all three counters and err_o on the next edge, overriding any increment that cycle. It does not affect the FSM or the wait timer.
- Reset during WAIT returns to RUN immediately. The outputs then reflect the current inputs.
- A hazard on register 0 never stalls.

Test Plan:
- Load-use: ID_EX_MemRead_i=1, ID_EX_RTaddr_i=5, IF_ID_RSaddr_i=5 for 1 cycle -> PC_write_o=0, IF_ID_write_o=0, ID_EX_bubble_o=1 that cycle; stall_cnt_o=1 after the edge. Repeat with addr 0 -> no stall, stall_cnt_o unchanged.
- Branch: branch_taken_i=1 with no hazards -> IF_ID_flush_o=1, PC_write_o=1; flush_cnt_o=1. Branch coincident with load-use on rt=7 -> bubble only, IF_ID_flush_o=0, flush_cnt_o unchanged.
- Memory wait: dmem_req_i=1, dmem_ready_i=0 for 3 cycles, then ready=1 -> pipe_stall_o=1 and PC_write_o=0 for 3 cycles, released in the ready cycle; wait_cnt_o=3; state back in RUN; err_o=0.
- Timeout: TIMEOUT=4, hold memwait 6 cycles -> err_o rises after the 4th WAIT cycle and stays 1 after ready. cnt_clr_i pulse -> err_o=0 and all counters 0.
- Saturation: CNT_W=3, force 10 load-use cycles -> stall_cnt_o=7, no wrap.
- Reset mid-wait: assert rst_i=0 in cycle 2 of WAIT -> counters 0 and err_o=0 immediately (async). After release with memwait=0 -> PC_write_o=1, pipe_stall_o=0.
